// File: rtl/spi_cap_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cap_packetizer
//  Description : Buffers completed SPI do/di capture pairs in a small FIFO
//                and serialises each one into a fixed 10-byte packet on a
//                valid/ready byte stream. Dropped captures are reported in
//                the packet status byte and by a saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_cap_packetizer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
   input  logic                          clk,
   input  logic                          rst,            // active-low, asynchronous
   input  logic                          spi_cap_ready,
   input  logic [31:0]                   spi_cap_do,
   input  logic [31:0]                   spi_cap_di,
   output logic                          tx_valid,
   output logic [7:0]                    tx_data,
   input  logic                          tx_ready,
   output logic [15:0]                   drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int unsigned c_ptr_w = $clog2(FIFO_DEPTH);
   localparam int unsigned c_cnt_w = c_ptr_w + 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t               state_q,    state_d;
   logic [63:0]          mem_q [FIFO_DEPTH];
   logic [c_ptr_w-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [c_ptr_w-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [c_cnt_w-1:0]   count_q,    count_d;
   logic [63:0]          pkt_q,      pkt_d;
   logic                 ovf_q,      ovf_d;
   logic [6:0]           pkt_seq_q,  pkt_seq_d;
   logic [6:0]           seq_q,      seq_d;
   logic                 pend_q,     pend_d;
   logic [3:0]           byte_idx_q, byte_idx_d;
   logic [15:0]          drop_cnt_q, drop_cnt_d;

   logic                 fifo_full;
   logic                 fifo_nonempty;
   logic                 load;
   logic                 push_ok;
   logic                 drop;
   logic [7:0]           cur_byte;

   assign fifo_full     = (count_q == c_cnt_w'(FIFO_DEPTH));
   assign fifo_nonempty = (count_q != '0);

   // A pop frees a slot in the same edge, so a full FIFO still accepts a push then.
   assign push_ok = spi_cap_ready && (!fifo_full || load);
   assign drop    = spi_cap_ready && fifo_full && !load;

   // Selects the packet byte addressed by byte_idx from the packet register.
   always_comb begin
      cur_byte = 8'h00;
      unique case (byte_idx_q)
         4'd0:    cur_byte = SYNC_BYTE;
         4'd1:    cur_byte = {ovf_q, pkt_seq_q};
         4'd2:    cur_byte = pkt_q[63:56];
         4'd3:    cur_byte = pkt_q[55:48];
         4'd4:    cur_byte = pkt_q[47:40];
         4'd5:    cur_byte = pkt_q[39:32];
         4'd6:    cur_byte = pkt_q[31:24];
         4'd7:    cur_byte = pkt_q[23:16];
         4'd8:    cur_byte = pkt_q[15:8];
         4'd9:    cur_byte = pkt_q[7:0];
         default: cur_byte = 8'h00;
      endcase
   end

   // Packet FSM: next state, packet load and byte stream outputs.
   always_comb begin
      state_d    = state_q;
      pkt_d      = pkt_q;
      ovf_d      = ovf_q;
      pkt_seq_d  = pkt_seq_q;
      byte_idx_d = byte_idx_q;
      load       = 1'b0;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;

      unique case (state_q)
         ST_IDLE: begin
            if (fifo_nonempty) begin
               load = 1'b1;
            end
         end
         ST_SEND: begin
            tx_valid = 1'b1;
            tx_data  = cur_byte;
            if (tx_ready) begin
               if (byte_idx_q == 4'd9) begin
                  // Last byte leaves: chain straight into the next packet if one waits.
                  if (fifo_nonempty) begin
                     load = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  byte_idx_d = byte_idx_q + 4'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load) begin
         pkt_d      = mem_q[rd_ptr_q];
         ovf_d      = pend_q;
         pkt_seq_d  = seq_q;
         byte_idx_d = 4'd0;
         state_d    = ST_SEND;
      end
   end

   // FIFO pointers, occupancy, sequence number and drop bookkeeping.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      seq_d      = seq_q;
      pend_d     = pend_q;
      drop_cnt_d = drop_cnt_q;

      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
      end
      if (load) begin
         rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
         seq_d    = seq_q + 7'd1;
         pend_d   = 1'b0;
      end

      unique case ({push_ok, load})
         2'b10:   count_d = count_q + c_cnt_w'(1);
         2'b01:   count_d = count_q - c_cnt_w'(1);
         default: count_d = count_q;
      endcase

      // A drop seen on a load edge is reported by the following packet.
      if (drop) begin
         pend_d = 1'b1;
         if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
         end
      end
   end

   // Control and packet state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         pkt_q      <= '0;
         ovf_q      <= 1'b0;
         pkt_seq_q  <= '0;
         seq_q      <= '0;
         pend_q     <= 1'b0;
         byte_idx_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         pkt_q      <= pkt_d;
         ovf_q      <= ovf_d;
         pkt_seq_q  <= pkt_seq_d;
         seq_q      <= seq_d;
         pend_q     <= pend_d;
         byte_idx_q <= byte_idx_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // FIFO storage; contents are only meaningful behind the pointers, so no reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= {spi_cap_do, spi_cap_di};
      end
   end

   assign drop_cnt   = drop_cnt_q;
   assign fifo_count = count_q;

endmodule
`default_nettype wire
